// File: rtl/prach_readout_sched.sv
// Round-robin job scheduler for the shared PRACH buffer readout/FFT path.
// One job at a time: grant on fft_ready, hold until job_done or timeout, then an idle gap.
module prach_readout_sched #(
    parameter int N_REQ      = 24,
    parameter int HDR_W      = 120,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*HDR_W-1:0]     hdr_in,
    input  logic                       fft_ready,
    input  logic                       job_done,
    output logic [N_REQ-1:0]           ack,
    output logic [$clog2(N_REQ)-1:0]   grant_idx,
    output logic [HDR_W-1:0]           hdr_out,
    output logic                       start,
    output logic                       busy,
    output logic                       timeout_err,
    output logic [$clog2(N_REQ)-1:0]   err_idx
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_d;
    logic [N_REQ-1:0]   ack_d;
    logic [IDX_W-1:0]   grant_idx_d;
    logic [HDR_W-1:0]   hdr_out_d;
    logic               start_d;
    logic               timeout_err_d;
    logic [IDX_W-1:0]   err_idx_d;
    logic [CNT_W-1:0]   run_cnt, run_cnt_d;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_d;

    logic [HDR_W-1:0]   hdr_arr [N_REQ];
    logic               arb_found;
    logic [IDX_W-1:0]   arb_idx;
    logic [IDX_W:0]     cand;
    logic [IDX_W-1:0]   next_ptr;

    for (genvar g = 0; g < N_REQ; g++) begin : g_hdr
        assign hdr_arr[g] = hdr_in[g*HDR_W +: HDR_W];
    end

    // First set request at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_REQ)) begin
                cand = cand - (IDX_W+1)'(N_REQ);
            end
            if (!arb_found && req[cand[IDX_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign next_ptr = (grant_idx == IDX_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
    assign busy     = (state_q != IDLE);

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr;
        ack_d         = ack;
        grant_idx_d   = grant_idx;
        hdr_out_d     = hdr_out;
        start_d       = 1'b0;
        timeout_err_d = 1'b0;
        err_idx_d     = err_idx;
        run_cnt_d     = run_cnt;
        gap_cnt_d     = gap_cnt;
        case (state_q)
            IDLE: begin
                if (fft_ready && arb_found) begin
                    state_d     = RUN;
                    ack_d       = {{(N_REQ-1){1'b0}}, 1'b1} << arb_idx;
                    grant_idx_d = arb_idx;
                    hdr_out_d   = hdr_arr[arb_idx];
                    start_d     = 1'b1;
                    run_cnt_d   = '0;
                end
            end
            RUN: begin
                // Done takes priority over a timeout landing in the same cycle.
                if (job_done || run_cnt == CNT_W'(TIMEOUT-1)) begin
                    ack_d     = '0;
                    rr_ptr_d  = next_ptr;
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
                    if (!job_done) begin
                        timeout_err_d = 1'b1;
                        err_idx_d     = grant_idx;
                    end
                end else begin
                    run_cnt_d = run_cnt + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_W'(GAP_CYCLES-1)) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr      <= '0;
            ack         <= '0;
            grant_idx   <= '0;
            hdr_out     <= '0;
            start       <= 1'b0;
            timeout_err <= 1'b0;
            err_idx     <= '0;
            run_cnt     <= '0;
            gap_cnt     <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr      <= rr_ptr_d;
            ack         <= ack_d;
            grant_idx   <= grant_idx_d;
            hdr_out     <= hdr_out_d;
            start       <= start_d;
            timeout_err <= timeout_err_d;
            err_idx     <= err_idx_d;
            run_cnt     <= run_cnt_d;
            gap_cnt     <= gap_cnt_d;
        end
    end

endmodule

// File: tb/tb_prach_readout_sched.sv
// Bench for prach_readout_sched: directed scenarios plus randomized job streams
// checked against a round-robin/timing model; a second instance covers timeout and zero gap.
module tb_prach_readout_sched;

    localparam int N_REQ = 24;
    localparam int HDR_W = 120;
    localparam int GAP   = 4;
    localparam int IDX_W = $clog2(N_REQ);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N_REQ-1:0]       req_a, req_b;
    logic [N_REQ*HDR_W-1:0] hdr_in;
    logic                   fft_ready_a, fft_ready_b, job_done_a, job_done_b;
    logic [HDR_W-1:0]       hdr_tbl [N_REQ];

    logic [N_REQ-1:0] ack_a, ack_b;
    logic [IDX_W-1:0] grant_idx_a, grant_idx_b, err_idx_a, err_idx_b;
    logic [HDR_W-1:0] hdr_out_a, hdr_out_b;
    logic             start_a, start_b, busy_a, busy_b, timeout_err_a, timeout_err_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int model_ptr = 0;

    for (genvar g = 0; g < N_REQ; g++) begin : g_hdr
        assign hdr_in[g*HDR_W +: HDR_W] = hdr_tbl[g];
    end

    prach_readout_sched dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .hdr_in(hdr_in),
        .fft_ready(fft_ready_a), .job_done(job_done_a), .ack(ack_a),
        .grant_idx(grant_idx_a), .hdr_out(hdr_out_a), .start(start_a),
        .busy(busy_a), .timeout_err(timeout_err_a), .err_idx(err_idx_a)
    );

    prach_readout_sched #(.TIMEOUT(16), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .hdr_in(hdr_in),
        .fft_ready(fft_ready_b), .job_done(job_done_b), .ack(ack_b),
        .grant_idx(grant_idx_b), .hdr_out(hdr_out_b), .start(start_b),
        .busy(busy_b), .timeout_err(timeout_err_b), .err_idx(err_idx_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [N_REQ-1:0] r, input logic fr, input logic jd);
        req_a       = r;
        fft_ready_a = fr;
        job_done_a  = jd;
    endtask

    function automatic logic [N_REQ-1:0] onehot(input int idx);
        logic [N_REQ-1:0] oh = '0;
        oh[IDX_W'(idx)] = 1'b1;
        return oh;
    endfunction

    // Reference rule: first requester at or after the pointer, modulo N_REQ.
    function automatic int rr_pick(input logic [N_REQ-1:0] r, input int ptr);
        for (int k = 0; k < N_REQ; k++) begin
            int c = (ptr + k) % N_REQ;
            if (r[IDX_W'(c)]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N_REQ-1:0] randReq();
        logic [31:0] a = $urandom();
        logic [31:0] b = $urandom();
        logic [N_REQ-1:0] r = a[N_REQ-1:0] & b[N_REQ-1:0];
        logic [IDX_W-1:0] k = IDX_W'($urandom_range(0, N_REQ-1));
        if (r == '0) r[k] = 1'b1;
        return r;
    endfunction

    task automatic randHeaders();
        logic [127:0] t;
        for (int i = 0; i < N_REQ; i++) begin
            t = {$urandom(), $urandom(), $urandom(), $urandom()};
            hdr_tbl[i] = t[HDR_W-1:0];
        end
    endtask

    task automatic waitStartA(input int budget);
        int n = 0;
        while (start_a !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checkOutput("start_arrives", 128'(start_a), 128'(1));
    endtask

    task automatic checkGrantA(input int idx);
        checkOutput("ack_onehot", 128'(ack_a), 128'(onehot(idx)));
        checkOutput("grant_idx", 128'(grant_idx_a), 128'(idx));
        checkOutput("hdr_out", 128'(hdr_out_a), 128'(hdr_tbl[IDX_W'(idx)]));
        checkOutput("start_set", 128'(start_a), 128'(1));
        checkOutput("busy_run", 128'(busy_a), 128'(1));
    endtask

    // Called on the start cycle; raises job_done len cycles later.
    task automatic finishJobA(input int idx, input int len);
        for (int i = 0; i < len; i++) begin
            tick();
            if (i == 0) checkOutput("start_one_cycle", 128'(start_a), 128'(0));
        end
        checkOutput("ack_held", 128'(ack_a), 128'(onehot(idx)));
        job_done_a = 1'b1;
        tick();
        job_done_a = 1'b0;
        checkOutput("ack_drop", 128'(ack_a), 128'(0));
        checkOutput("no_timeout", 128'(timeout_err_a), 128'(0));
        checkOutput("busy_gap", 128'(busy_a), 128'(1));
        model_ptr = (idx + 1) % N_REQ;
    endtask

    task automatic checkResetA();
        checkOutput("rst_ack", 128'(ack_a), 128'(0));
        checkOutput("rst_grant_idx", 128'(grant_idx_a), 128'(0));
        checkOutput("rst_hdr_out", 128'(hdr_out_a), 128'(0));
        checkOutput("rst_start", 128'(start_a), 128'(0));
        checkOutput("rst_busy", 128'(busy_a), 128'(0));
        checkOutput("rst_timeout_err", 128'(timeout_err_a), 128'(0));
        checkOutput("rst_err_idx", 128'(err_idx_a), 128'(0));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int idx, len, prev_len, start_cyc, bad, hi;
        logic [N_REQ-1:0] r;

        rst_n = 1'b0;
        applyStimulus('0, 1'b0, 1'b0);
        req_b = '0; fft_ready_b = 1'b0; job_done_b = 1'b0;
        randHeaders();
        repeat (3) tick();
        checkResetA();
        rst_n = 1'b1;

        // Single requester, long job, request dropped mid-run.
        hdr_tbl[5] = 120'hA5;
        applyStimulus(onehot(5), 1'b1, 1'b0);
        tick();
        checkGrantA(5);
        applyStimulus('0, 1'b0, 1'b0);
        finishJobA(5, 2046);
        job_done_a = 1'b1;
        tick();
        job_done_a = 1'b0;
        repeat (2) tick();
        checkOutput("busy_still_gap", 128'(busy_a), 128'(1));
        tick();
        checkOutput("busy_low_after_gap", 128'(busy_a), 128'(0));

        // Not ready: request must wait.
        applyStimulus(onehot(7), 1'b0, 1'b0);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (ack_a !== '0 || start_a !== 1'b0) bad++;
        end
        checkOutput("not_ready_quiet", 128'(bad), 128'(0));
        fft_ready_a = 1'b1;
        tick();
        checkGrantA(7);

        // Wrap from 23 to 2, with single-cycle jobs.
        r = onehot(2) | onehot(23);
        req_a = r;
        finishJobA(7, 0);
        waitStartA(20);
        checkGrantA(23);
        finishJobA(23, 0);
        waitStartA(20);
        checkGrantA(2);
        finishJobA(2, 3);

        // Reset in the middle of a job on requester 9.
        req_a = onehot(9) | onehot(0);
        waitStartA(20);
        checkGrantA(9);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        checkResetA();
        rst_n = 1'b1;
        model_ptr = 0;
        tick();
        checkGrantA(0);
        finishJobA(0, 5);

        // Three held requesters, fixed job length, fixed spacing.
        rst_n = 1'b0;
        req_a = onehot(0) | onehot(3) | onehot(23);
        tick();
        rst_n = 1'b1;
        model_ptr = 0;
        start_cyc = 0;
        for (int j = 0; j < 5; j++) begin
            int order [5] = '{0, 3, 23, 0, 3};
            waitStartA(40);
            checkGrantA(order[j]);
            if (j > 0) checkOutput("spacing16", 128'(cyc - start_cyc), 128'(16));
            start_cyc = cyc;
            finishJobA(order[j], 10);
        end

        // Randomized request sets, headers and job lengths.
        prev_len = 0;
        for (int j = 0; j < 12; j++) begin
            req_a = randReq();
            randHeaders();
            waitStartA(60);
            idx = rr_pick(req_a, model_ptr);
            checkGrantA(idx);
            if (j > 0) checkOutput("spacing_rand", 128'(cyc - start_cyc), 128'(prev_len + GAP + 2));
            start_cyc = cyc;
            len = $urandom_range(0, 20);
            prev_len = len;
            finishJobA(idx, len);
        end
        req_a = '0;

        // Timeout instance: TIMEOUT=16, no gap.
        req_b = onehot(2);
        fft_ready_b = 1'b1;
        tick();
        checkOutput("b_start", 128'(start_b), 128'(1));
        checkOutput("b_ack", 128'(ack_b), 128'(onehot(2)));
        hi = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ack_b[2]) hi++;
            else break;
        end
        checkOutput("b_ack_high_cycles", 128'(hi), 128'(16));
        checkOutput("b_timeout_err", 128'(timeout_err_b), 128'(1));
        checkOutput("b_err_idx", 128'(err_idx_b), 128'(2));
        checkOutput("b_busy_nogap", 128'(busy_b), 128'(0));
        tick();
        checkOutput("b_regrant_start", 128'(start_b), 128'(1));
        checkOutput("b_regrant_idx", 128'(grant_idx_b), 128'(2));
        checkOutput("b_timeout_pulse", 128'(timeout_err_b), 128'(0));
        repeat (15) tick();
        job_done_b = 1'b1;
        tick();
        job_done_b = 1'b0;
        checkOutput("b_done_wins_ack", 128'(ack_b), 128'(0));
        checkOutput("b_done_wins_err", 128'(timeout_err_b), 128'(0));
        checkOutput("b_busy_after_done", 128'(busy_b), 128'(0));
        tick();
        checkOutput("b_spacing2", 128'(start_b), 128'(1));
        req_b = '0;
        job_done_b = 1'b1;
        tick();
        job_done_b = 1'b0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
